// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue
// Brief    : RV32I decode / issue stage with a register scoreboard. Decodes
//            the fetched instruction, reads operands, stalls on pending
//            registers and holds one decoded instruction for execute.
// Revision : 1.0 - initial release
// ============================================================================
module decode_issue #(
  parameter int SB_ENABLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  read_addr0,
  output logic [4:0]  read_addr1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic        out_illegal
);

  // RV32I base opcodes
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;

  // Instruction fields
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_funct7;

  // Decode results
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic        w_rd_used;
  logic        w_illegal;
  logic [31:0] w_imm;
  logic [4:0]  w_rd_eff;

  logic        w_hazard;
  logic        w_issue;

  // Output register and scoreboard state
  logic        out_valid_q,   out_valid_d;
  logic [31:0] out_pc_q,      out_pc_d;
  logic [31:0] out_rs1_val_q, out_rs1_val_d;
  logic [31:0] out_rs2_val_q, out_rs2_val_d;
  logic [31:0] out_imm_q,     out_imm_d;
  logic [4:0]  out_rd_q,      out_rd_d;
  logic [6:0]  out_opcode_q,  out_opcode_d;
  logic [2:0]  out_funct3_q,  out_funct3_d;
  logic [6:0]  out_funct7_q,  out_funct7_d;
  logic        out_illegal_q, out_illegal_d;
  logic [31:0] pend_q,        pend_d;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign w_funct3 = in_instr[14:12];
  assign w_rs1    = in_instr[19:15];
  assign w_rs2    = in_instr[24:20];
  assign w_funct7 = in_instr[31:25];

  // Register file addresses come straight from the instruction word.
  assign read_addr0 = w_rs1;
  assign read_addr1 = w_rs2;

  // Classify the opcode: which register fields it uses and its immediate.
  always_comb begin
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    w_rd_used  = 1'b0;
    w_illegal  = 1'b0;
    w_imm      = 32'h0000_0000;
    case (w_opcode)
      c_OP_LUI, c_OP_AUIPC: begin
        w_rd_used = 1'b1;
        w_imm     = {in_instr[31:12], 12'h000};
      end
      c_OP_JAL: begin
        w_rd_used = 1'b1;
        w_imm     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      c_OP_JALR, c_OP_LOAD, c_OP_OPIMM: begin
        w_rs1_used = 1'b1;
        w_rd_used  = 1'b1;
        w_imm      = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      c_OP_BRANCH: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_imm      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      end
      c_OP_STORE: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_imm      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      c_OP_OP: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_rd_used  = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Destination as seen by the scoreboard and execute: 0 when unused.
  assign w_rd_eff = w_rd_used ? w_rd : 5'd0;

  // RAW on either used source, WAW on a used non-zero destination.
  assign w_hazard = (SB_ENABLE != 0) && in_valid &&
                    ((w_rs1_used && pend_q[w_rs1]) ||
                     (w_rs2_used && pend_q[w_rs2]) ||
                     (w_rd_used && (w_rd != 5'd0) && pend_q[w_rd]));

  assign in_ready = !rst && !w_hazard && (!out_valid_q || out_ready) && !flush;
  assign w_issue  = in_valid && in_ready;

  // Next state of the output register and scoreboard.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_rs1_val_d = out_rs1_val_q;
    out_rs2_val_d = out_rs2_val_q;
    out_imm_d     = out_imm_q;
    out_rd_d      = out_rd_q;
    out_opcode_d  = out_opcode_q;
    out_funct3_d  = out_funct3_q;
    out_funct7_d  = out_funct7_q;
    out_illegal_d = out_illegal_q;
    pend_d        = pend_q;

    if (w_issue) begin
      out_valid_d   = 1'b1;
      out_pc_d      = in_pc;
      out_rs1_val_d = w_rs1_used ? data0 : 32'h0000_0000;
      out_rs2_val_d = w_rs2_used ? data1 : 32'h0000_0000;
      out_imm_d     = w_imm;
      out_rd_d      = w_rd_eff;
      out_opcode_d  = w_opcode;
      out_funct3_d  = w_funct3;
      out_funct7_d  = w_funct7;
      out_illegal_d = w_illegal;
    end else if (flush) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clears first, then the issue set, so a same-cycle set wins.
    if (flush && out_valid_q && (out_rd_q != 5'd0)) begin
      pend_d[out_rd_q] = 1'b0;
    end
    if (wb_valid && (wb_addr != 5'd0)) begin
      pend_d[wb_addr] = 1'b0;
    end
    if (w_issue && (w_rd_eff != 5'd0)) begin
      pend_d[w_rd_eff] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // State registers; reset drops the held instruction and all pending bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= 32'h0000_0000;
      out_rs1_val_q <= 32'h0000_0000;
      out_rs2_val_q <= 32'h0000_0000;
      out_imm_q     <= 32'h0000_0000;
      out_rd_q      <= 5'd0;
      out_opcode_q  <= 7'd0;
      out_funct3_q  <= 3'd0;
      out_funct7_q  <= 7'd0;
      out_illegal_q <= 1'b0;
      pend_q        <= 32'h0000_0000;
    end else begin
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_rs1_val_q <= out_rs1_val_d;
      out_rs2_val_q <= out_rs2_val_d;
      out_imm_q     <= out_imm_d;
      out_rd_q      <= out_rd_d;
      out_opcode_q  <= out_opcode_d;
      out_funct3_q  <= out_funct3_d;
      out_funct7_q  <= out_funct7_d;
      out_illegal_q <= out_illegal_d;
      pend_q        <= pend_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_rs1_val = out_rs1_val_q;
  assign out_rs2_val = out_rs2_val_q;
  assign out_imm     = out_imm_q;
  assign out_rd      = out_rd_q;
  assign out_opcode  = out_opcode_q;
  assign out_funct3  = out_funct3_q;
  assign out_funct7  = out_funct7_q;
  assign out_illegal = out_illegal_q;

endmodule
`default_nettype wire
